// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard-detection inputs from the pipeline and the
// stall/flush controls plus performance counters returned to it.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_branch_taken;
   logic             imem_ready;
   logic             ext_stall_req;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
             imem_ready, ext_stall_req,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
             stall_cycles, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
             imem_ready, ext_stall_req,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
             stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and PC sequencing for the 5-stage core: load-use stalls, branch
// flushes, fetch wait and external freeze, with saturating perf counters.
module pipe_hazard_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   // state    | meaning
   // ST_RUN   | normal issue; hazard/branch/wait/freeze decided per cycle
   // ST_STALL | extra load-use bubbles remaining, cnt = bubbles left

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;
   localparam logic [2:0] LOAD_M1  = 3'(LOAD_STALL - 1);

   logic [0:0]       state, state_nxt;
   logic [2:0]       cnt, cnt_nxt;
   logic             hazard;
   logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic             flush_evt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      flush_evt    = 1'b0;
      state_nxt    = state;
      cnt_nxt      = cnt;
      if (reset) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_nxt    = ST_RUN;
         cnt_nxt      = 3'd0;
      end else if (bus.ex_branch_taken) begin
         // a redirect wins in either state and abandons any pending stall
         pc_write     = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         flush_evt    = 1'b1;
         state_nxt    = ST_RUN;
         cnt_nxt      = 3'd0;
      end else if (state == ST_STALL) begin
         if (!bus.ext_stall_req) begin
            id_ex_bubble = 1'b1;
            cnt_nxt      = cnt - 3'd1;
            if (cnt <= 3'd1) begin
               state_nxt = ST_RUN;
               cnt_nxt   = 3'd0;
            end
         end
      end else if (bus.ext_stall_req) begin
         pc_write = 1'b0;
      end else if (hazard) begin
         id_ex_bubble = 1'b1;
         if (LOAD_STALL > 1) begin
            state_nxt = ST_STALL;
            cnt_nxt   = LOAD_M1;
         end
      end else if (!bus.imem_ready) begin
         if_id_write = 1'b1;
         if_id_flush = 1'b1;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_evt && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.if_id_write  = if_id_write;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.stall_cycles = stall_cnt;
   assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: four instances (LOAD_STALL 1/2/3, plus a narrow
// counter copy) share one stimulus and are compared with a bubble-count model.
module tb_pipe_hazard_ctrl;
   logic clk, rst;
   logic br, ext, mrd, imem;
   logic [4:0] rd, rs1, rs2;
   int n_chk, n_fail;

   longint rem [4];
   longint sc  [4];
   longint fc  [4];
   int load_of  [4] = '{1, 2, 3, 2};
   int width_of [4] = '{32, 32, 32, 4};

   pipe_hazard_ctrl_if #(.CNT_W(32)) if1 ();
   pipe_hazard_ctrl_if #(.CNT_W(32)) if2 ();
   pipe_hazard_ctrl_if #(.CNT_W(32)) if3 ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  if4 ();

   pipe_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) dut1 (.clk(clk), .reset(rst), .bus(if1));
   pipe_hazard_ctrl #(.LOAD_STALL(2), .CNT_W(32)) dut2 (.clk(clk), .reset(rst), .bus(if2));
   pipe_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(32)) dut3 (.clk(clk), .reset(rst), .bus(if3));
   pipe_hazard_ctrl #(.LOAD_STALL(2), .CNT_W(4))  dut4 (.clk(clk), .reset(rst), .bus(if4));

   assign if1.id_rs1 = rs1;  assign if1.id_rs2 = rs2;  assign if1.ex_rd = rd;
   assign if1.ex_mem_read = mrd;  assign if1.ex_branch_taken = br;
   assign if1.imem_ready = imem;  assign if1.ext_stall_req = ext;
   assign if2.id_rs1 = rs1;  assign if2.id_rs2 = rs2;  assign if2.ex_rd = rd;
   assign if2.ex_mem_read = mrd;  assign if2.ex_branch_taken = br;
   assign if2.imem_ready = imem;  assign if2.ext_stall_req = ext;
   assign if3.id_rs1 = rs1;  assign if3.id_rs2 = rs2;  assign if3.ex_rd = rd;
   assign if3.ex_mem_read = mrd;  assign if3.ex_branch_taken = br;
   assign if3.imem_ready = imem;  assign if3.ext_stall_req = ext;
   assign if4.id_rs1 = rs1;  assign if4.id_rs2 = rs2;  assign if4.ex_rd = rd;
   assign if4.ex_mem_read = mrd;  assign if4.ex_branch_taken = br;
   assign if4.imem_ready = imem;  assign if4.ext_stall_req = ext;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       br, ext, mrd;
      logic [4:0] rd, rs1, rs2;
      logic       imem;
      logic [3:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
   } vec_t;

   function automatic logic [3:0] dut_outs(int k);
      case (k)
         0: return {if1.pc_write, if1.if_id_write, if1.if_id_flush, if1.id_ex_bubble};
         1: return {if2.pc_write, if2.if_id_write, if2.if_id_flush, if2.id_ex_bubble};
         2: return {if3.pc_write, if3.if_id_write, if3.if_id_flush, if3.id_ex_bubble};
         default: return {if4.pc_write, if4.if_id_write, if4.if_id_flush, if4.id_ex_bubble};
      endcase
   endfunction

   function automatic longint dut_sc(int k);
      case (k)
         0: return longint'(if1.stall_cycles);
         1: return longint'(if2.stall_cycles);
         2: return longint'(if3.stall_cycles);
         default: return longint'(if4.stall_cycles);
      endcase
   endfunction

   function automatic longint dut_fc(int k);
      case (k)
         0: return longint'(if1.flush_count);
         1: return longint'(if2.flush_count);
         2: return longint'(if3.flush_count);
         default: return longint'(if4.flush_count);
      endcase
   endfunction

   function automatic logic hazard_now();
      return mrd && (rd != 5'd0) && (rd == rs1 || rd == rs2);
   endfunction

   // rem[k] = extra bubbles still owed after the hazard cycle itself
   function automatic logic [3:0] model_outs(int k);
      if (rst)         return 4'b0011;
      if (br)          return 4'b1011;
      if (rem[k] > 0)  return ext ? 4'b0000 : 4'b0001;
      if (ext)         return 4'b0000;
      if (hazard_now()) return 4'b0001;
      if (!imem)       return 4'b0110;
      return 4'b1100;
   endfunction

   task automatic model_step(int k, logic [3:0] o);
      longint maxv;
      maxv = (longint'(1) << width_of[k]) - 1;
      if (rst) begin
         rem[k] = 0; sc[k] = 0; fc[k] = 0;
         return;
      end
      if (!o[3] && sc[k] < maxv) sc[k] = sc[k] + 1;
      if (br) begin
         if (fc[k] < maxv) fc[k] = fc[k] + 1;
         rem[k] = 0;
      end else if (rem[k] > 0) begin
         if (!ext) rem[k] = rem[k] - 1;
      end else if (!ext && hazard_now()) begin
         rem[k] = load_of[k] - 1;
      end
   endtask

   task automatic chk(string name, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic b, logic e, logic m, logic [4:0] d,
                        logic [4:0] s1, logic [4:0] s2, logic im);
      rst = r; br = b; ext = e; mrd = m; rd = d; rs1 = s1; rs2 = s2; imem = im;
   endtask

   // Called just after a negedge with inputs applied; returns at the next negedge.
   task automatic cycle();
      logic [3:0] o;
      #1;
      for (int k = 0; k < 4; k++) begin
         o = model_outs(k);
         chk($sformatf("outs_dut%0d", k), longint'(dut_outs(k)), longint'(o));
         model_step(k, o);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stall_cycles_dut%0d", k), dut_sc(k), sc[k]);
         chk($sformatf("flush_count_dut%0d", k), dut_fc(k), fc[k]);
      end
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
         cycle();
      end
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      cycle();
   endtask

   vec_t vecs [11];

   initial begin
      n_chk = 0; n_fail = 0;
      for (int k = 0; k < 4; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
      vecs[0]  = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 4'b1100};
      vecs[1]  = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 4'b0110};
      vecs[2]  = '{0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 4'b0001};
      vecs[3]  = '{0, 0, 1, 5'd9, 5'd2, 5'd9, 0, 4'b0001};
      vecs[4]  = '{0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 4'b1100};
      vecs[5]  = '{0, 0, 0, 5'd7, 5'd7, 5'd7, 1, 4'b1100};
      vecs[6]  = '{0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 4'b0000};
      vecs[7]  = '{0, 1, 1, 5'd4, 5'd4, 5'd4, 1, 4'b0000};
      vecs[8]  = '{1, 1, 1, 5'd4, 5'd4, 5'd4, 0, 4'b1011};
      vecs[9]  = '{1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 4'b1011};
      vecs[10] = '{0, 0, 1, 5'd6, 5'd5, 5'd4, 1, 4'b1100};

      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      @(negedge clk);

      // reset held 3 cycles, then free running
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
         #1;
         chk("reset_pc_write", longint'(if1.pc_write), 0);
         chk("reset_if_id_flush", longint'(if1.if_id_flush), 1);
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
         #1;
         chk("run_pc_write", longint'(if1.pc_write), 1);
         chk("run_if_id_write", longint'(if1.if_id_write), 1);
         cycle();
      end
      chk("run_stall_cycles", dut_sc(0), 0);
      chk("run_flush_count", dut_fc(0), 0);

      // single-cycle priority table on the LOAD_STALL=1 instance
      foreach (vecs[i]) begin
         drive(0, vecs[i].br, vecs[i].ext, vecs[i].mrd, vecs[i].rd,
               vecs[i].rs1, vecs[i].rs2, vecs[i].imem);
         #1;
         chk($sformatf("vec%0d_outs", i), longint'(dut_outs(0)), longint'(vecs[i].exp));
         cycle();
      end

      // one-cycle load-use hazard seen by all three stall depths
      do_reset();
      drive(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 1);
      #1;
      chk("ls1_hz_pc_write", longint'(if1.pc_write), 0);
      chk("ls1_hz_bubble", longint'(if1.id_ex_bubble), 1);
      cycle();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      #1;
      chk("ls1_after_pc_write", longint'(if1.pc_write), 1);
      chk("ls2_second_bubble", longint'(if2.id_ex_bubble), 1);
      chk("ls2_second_pc_write", longint'(if2.pc_write), 0);
      cycle();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      #1;
      chk("ls2_back_to_run", longint'(if2.pc_write), 1);
      cycle();
      idle(2);
      chk("ls1_stall_cycles", dut_sc(0), 1);
      chk("ls2_stall_cycles", dut_sc(1), 2);
      chk("ls3_stall_cycles", dut_sc(2), 3);

      // ex_rd = 0 never stalls
      do_reset();
      drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
      cycle();
      idle(2);
      chk("rd0_stall_cycles", dut_sc(1), 0);

      // hazard coinciding with a taken branch
      do_reset();
      drive(0, 1, 0, 1, 5'd5, 5'd0, 5'd5, 1);
      #1;
      chk("br_hz_flush", longint'(if2.if_id_flush), 1);
      chk("br_hz_pc_write", longint'(if2.pc_write), 1);
      cycle();
      idle(2);
      chk("br_hz_flush_count", dut_fc(1), 1);
      chk("br_hz_stall_cycles", dut_sc(1), 0);

      // LOAD_STALL=3 with a 2-cycle freeze inside the stall
      do_reset();
      drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1);
      cycle();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1);
         #1;
         chk("ls3_freeze_bubble", longint'(if3.id_ex_bubble), 0);
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
         #1;
         chk("ls3_resume_bubble", longint'(if3.id_ex_bubble), 1);
         cycle();
      end
      idle(1);
      chk("ls3_freeze_stall_cycles", dut_sc(2), 5);

      // reset in the middle of a stall
      do_reset();
      drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1);
      cycle();
      do_reset();
      drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      #1;
      chk("ls3_reset_mid_stall", longint'(if3.pc_write), 1);
      cycle();

      // fetch wait, then saturation of the narrow counters
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
         #1;
         chk("imem_wait_pc_write", longint'(if1.pc_write), 0);
         chk("imem_wait_flush", longint'(if1.if_id_flush), 1);
         cycle();
      end
      chk("imem_wait_stall_cycles", dut_sc(0), 4);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
         cycle();
      end
      chk("sat_stall_cycles", dut_sc(3), 15);
      for (int i = 0; i < 18; i++) begin
         drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
         cycle();
      end
      chk("sat_flush_count", dut_fc(3), 15);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom_range(0, 5) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
